// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write port between the in-order writeback
// stage (port A) and the long-latency MDU result port (port B), and keeps the
// busy scoreboard of registers owned by in-flight long ops for decode hazards.
//
// Handshake: port B uses valid/ready; a transfer happens on a cycle where
// b_valid & b_ready, and the MDU must hold b_addr/b_data stable until then.
// Port A has no ready; a_stall=1 means the writeback stage must hold A stable
// and present it again next cycle.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        w_en,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic        q_en_1,
    input  logic [4:0]  q_addr_1,
    input  logic        q_en_2,
    input  logic [4:0]  q_addr_2,
    input  logic        q_dst_en,
    input  logic [4:0]  q_dst_addr,
    output logic        hz_stall,
    output logic [31:0] busy_vec
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        b_win;
    logic        b_xfer;

    // Grant and write-port mux; r0 writes are handshaken but never enabled.
    always_comb begin
        b_win   = b_valid & (~a_valid | (starve_cnt == LIMIT));
        b_xfer  = b_win & ~rst;
        b_ready = b_xfer;
        a_stall = ~rst & b_win & a_valid;
        w_en    = 1'b0;
        w_addr  = 5'd0;
        w_data  = 32'd0;
        if (b_win) begin
            w_en   = ~rst & (b_addr != 5'd0);
            w_addr = b_addr;
            w_data = b_data;
        end else if (a_valid) begin
            w_en   = ~rst & (a_addr != 5'd0);
            w_addr = a_addr;
            w_data = a_data;
        end
    end

    // Count consecutive cycles B has waited; saturates at the force-through point.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!b_valid || b_xfer) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Next scoreboard: clear on B completion, then set on issue so a new owner wins.
    always_comb begin
        busy_next = busy;
        if (b_xfer) begin
            busy_next[b_addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    // Decode hazard on current scoreboard state; same-cycle clears rely on regfile bypass.
    always_comb begin
        hz_stall = ~rst & ((q_en_1 & busy[q_addr_1]) |
                           (q_en_2 & busy[q_addr_2]) |
                           (q_dst_en & busy[q_dst_addr]));
        busy_vec = busy;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr;
  logic [31:0] a_data, b_data;
  logic        q_en_1, q_en_2, q_dst_en;
  logic [4:0]  q_addr_1, q_addr_2, q_dst_addr;
  logic        a_stall, b_ready, w_en, hz_stall;
  logic [4:0]  w_addr;
  logic [31:0] w_data, busy_vec;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .q_en_1(q_en_1), .q_addr_1(q_addr_1),
    .q_en_2(q_en_2), .q_addr_2(q_addr_2),
    .q_dst_en(q_dst_en), .q_dst_addr(q_dst_addr),
    .hz_stall(hz_stall), .busy_vec(busy_vec)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int m_wait;           // cycles B has been waiting
  bit m_busy[32];       // registers owned by in-flight long ops
  bit m_b_taken;        // B transferred in the current cycle
  bit m_a_held;         // A told to hold in the current cycle

  // {chk_wdata, a_stall, b_ready, w_en, hz_stall, w_addr, w_data, busy_vec}
  logic [73:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_word();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Expected outputs for the current inputs and model state.
  function automatic logic [73:0] predict();
    bit b_take, wen, hz, stall, rdy;
    logic [4:0] addr;
    logic [31:0] data;
    b_take = b_valid && (!a_valid || m_wait == LIMIT);
    addr = 5'd0;
    data = 32'd0;
    if (b_take) begin
      addr = b_addr; data = b_data;
    end else if (a_valid) begin
      addr = a_addr; data = a_data;
    end
    wen   = !rst && (b_take || a_valid) && addr != 5'd0;
    rdy   = !rst && b_take;
    stall = !rst && b_take && a_valid;
    hz    = !rst && ((q_en_1 && m_busy[q_addr_1]) || (q_en_2 && m_busy[q_addr_2]) ||
                     (q_dst_en && m_busy[q_dst_addr]));
    return {!rst, stall, rdy, wen, hz, addr, data, model_busy_word()};
  endfunction

  // Called at negedge: compare DUT against model prediction.
  task automatic sample(input bit do_check);
    logic [73:0] e;
    exp_q.push_back(predict());
    e = exp_q.pop_front();
    m_a_held  = e[72];
    m_b_taken = e[71];
    if (do_check) begin
      check("a_stall", {31'd0, a_stall}, {31'd0, e[72]});
      check("b_ready", {31'd0, b_ready}, {31'd0, e[71]});
      check("w_en", {31'd0, w_en}, {31'd0, e[70]});
      check("hz_stall", {31'd0, hz_stall}, {31'd0, e[69]});
      check("busy_vec", busy_vec, e[31:0]);
      if (e[73]) begin
        check("w_addr", {27'd0, w_addr}, {27'd0, e[68:64]});
        check("w_data", w_data, e[63:32]);
      end
    end
  endtask

  // Cross the posedge, update the model the way the rules say, settle inputs time.
  task automatic end_cycle();
    @(posedge clk);
    if (rst) begin
      m_wait = 0;
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (!b_valid || m_b_taken) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      if (m_b_taken) m_busy[b_addr] = 0;
      if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0;
    q_en_1 = 0; q_addr_1 = 0; q_en_2 = 0; q_addr_2 = 0;
    q_dst_en = 0; q_dst_addr = 0;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    a_valid = v; a_addr = ad; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    b_valid = v; b_addr = ad; b_data = d;
  endtask

  task automatic drive_iss(input logic v, input logic [4:0] ad);
    iss_valid = v; iss_addr = ad;
  endtask

  task automatic drive_random_queries();
    q_en_1 = 1'($urandom_range(0, 1)); q_addr_1 = 5'($urandom_range(0, 31));
    q_en_2 = 1'($urandom_range(0, 1)); q_addr_2 = 5'($urandom_range(0, 31));
    q_dst_en = 1'($urandom_range(0, 1)); q_dst_addr = 5'($urandom_range(0, 31));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_wait = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    drive_idle();
    rst = 1;
    drive_a(1, 5'd3, 32'hAAAA_0001);
    drive_b(1, 5'd4, 32'hBBBB_0001);
    #1;

    // Reset held with both ports requesting: nothing granted, scoreboard clear.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      sample(c > 0);
      check("rst_w_en", {31'd0, w_en}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
      if (c > 0) check("rst_busy", busy_vec, 32'd0);
      end_cycle();
    end
    rst = 0;
    drive_idle();

    // A alone writes straight through.
    drive_a(1, 5'd5, 32'h1234);
    @(negedge clk); sample(1);
    check("a_only_w_en", {31'd0, w_en}, 32'd1);
    check("a_only_w_addr", {27'd0, w_addr}, 32'd5);
    check("a_only_w_data", w_data, 32'h1234);
    check("a_only_a_stall", {31'd0, a_stall}, 32'd0);
    end_cycle();

    // Both held: A wins four cycles, B forced on the fifth, then A again.
    drive_a(1, 5'd3, 32'h3333);
    drive_b(1, 5'd12, 32'hC0DE);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); sample(1);
      if (c < 4) begin
        check("starve_a_win_addr", {27'd0, w_addr}, 32'd3);
        check("starve_b_ready_lo", {31'd0, b_ready}, 32'd0);
        check("starve_a_stall_lo", {31'd0, a_stall}, 32'd0);
      end else if (c == 4) begin
        check("starve_b_win_addr", {27'd0, w_addr}, 32'd12);
        check("starve_b_ready_hi", {31'd0, b_ready}, 32'd1);
        check("starve_a_stall_hi", {31'd0, a_stall}, 32'd1);
      end else begin
        check("starve_a_again_addr", {27'd0, w_addr}, 32'd3);
        check("starve_a_again_stall", {31'd0, a_stall}, 32'd0);
      end
      end_cycle();
      if (c == 4) drive_b(0, 5'd0, 32'd0);
    end
    drive_idle();

    // Issue to r7, decode sees hazard; B retires r7, hazard gone next cycle.
    drive_iss(1, 5'd7);
    @(negedge clk); sample(1); end_cycle();
    drive_iss(0, 5'd0);
    q_en_1 = 1; q_addr_1 = 5'd7;
    drive_b(1, 5'd7, 32'h7777);
    @(negedge clk); sample(1);
    check("raw_hz_set", {31'd0, hz_stall}, 32'd1);
    check("raw_busy7_set", {31'd0, busy_vec[7]}, 32'd1);
    end_cycle();
    drive_b(0, 5'd0, 32'd0);
    @(negedge clk); sample(1);
    check("raw_hz_clear", {31'd0, hz_stall}, 32'd0);
    check("raw_busy7_clear", {31'd0, busy_vec[7]}, 32'd0);
    end_cycle();
    drive_idle();

    // Same-cycle set and clear of r9: new owner keeps the bit.
    drive_iss(1, 5'd9);
    @(negedge clk); sample(1); end_cycle();
    drive_b(1, 5'd9, 32'h9999);
    @(negedge clk); sample(1); end_cycle();
    drive_idle();
    @(negedge clk); sample(1);
    check("setclr_busy9", {31'd0, busy_vec[9]}, 32'd1);
    end_cycle();

    // Retire r9 so the scoreboard is empty again.
    drive_b(1, 5'd9, 32'h9999);
    @(negedge clk); sample(1); end_cycle();
    drive_idle();

    // r0: A write handshaken but not enabled; issue to r0 ignored.
    drive_a(1, 5'd0, 32'hDEAD);
    drive_iss(1, 5'd0);
    @(negedge clk); sample(1);
    check("r0_a_stall", {31'd0, a_stall}, 32'd0);
    check("r0_w_en", {31'd0, w_en}, 32'd0);
    end_cycle();
    drive_idle();
    @(negedge clk); sample(1);
    check("r0_busy_empty", busy_vec, 32'd0);
    end_cycle();

    // Randomized traffic; A holds while stalled, B holds until accepted.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(a_valid && m_a_held)) begin
        drive_a(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom);
      end
      if (!(b_valid && !m_b_taken) || rst) begin
        drive_b(1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), $urandom);
      end
      drive_iss(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      drive_random_queries();
      @(negedge clk); sample(1);
      end_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
